// File: rtl/integ_sched_pkg.sv
// rtl/integ_sched_pkg.sv - shared state type, default widths and overrun counter width for the integration scheduler
package integ_sched_pkg;

    localparam int DEF_CNT_W      = 32;
    localparam int DEF_NWIN_W     = 16;
    localparam int DEF_ALIGN_LOG2 = 10;
    localparam int OVR_CNT_W      = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_HOLDOFF,
        S_INTEGRATE,
        S_CLOSE
    } sched_state_t;

endpackage

// File: rtl/sample_window_counter.sv
// rtl/sample_window_counter.sv - sample counter with clear/seed, enable and terminal-count flag against a preset
module sample_window_counter
    import integ_sched_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             seed,
    input  logic             en,
    input  logic [CNT_W-1:0] preset,
    output logic [CNT_W-1:0] count,
    output logic             term
);

    // A clear may seed the count with a coincident sample so a new window starts at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= CNT_W'(seed);
        end else if (en && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    // Asserted in the cycle whose sample brings the count up to the preset.
    assign term = en && ((count + CNT_W'(1)) == preset);

endmodule

// File: rtl/integration_scheduler.sv
// rtl/integration_scheduler.sv - arm/trigger/holdoff/window sequencer for ADC capture; optional INTEG_SCHED_TS_ALIGN_EN
module integration_scheduler
    import integ_sched_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int NWIN_W     = DEF_NWIN_W,
    parameter int ALIGN_LOG2 = DEF_ALIGN_LOG2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arm,
    input  logic                 abort,
    input  logic                 ext_trigger,
    input  logic [CNT_W-1:0]     cfg_window_len,
    input  logic [CNT_W-1:0]     cfg_holdoff,
    input  logic [NWIN_W-1:0]    cfg_num_windows,
    input  logic                 sample_valid,
    input  logic [63:0]          in_timestamp,
    input  logic                 pkt_busy,
    output logic                 cap_ena,
    output logic                 cap_start,
    output logic                 cap_capture,
    output logic [NWIN_W-1:0]    win_index,
    output logic [63:0]          win_ts,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    output logic [OVR_CNT_W-1:0] overrun_cnt
);

    sched_state_t      state;
    logic [CNT_W-1:0]  len_sh;
    logic [CNT_W-1:0]  hold_sh;
    logic [NWIN_W-1:0] num_sh;
    logic              last_win;

    logic              cnt_clr;
    logic              cnt_seed;
    logic [CNT_W-1:0]  cnt_preset;
    logic [CNT_W-1:0]  cnt_count;
    logic              cnt_term;
    logic              trig;
    logic [NWIN_W-1:0] win_next;
    logic              final_integ;
    logic              final_close;

`ifdef INTEG_SCHED_TS_ALIGN_EN
    assign trig = ext_trigger || (sample_valid && (in_timestamp[ALIGN_LOG2-1:0] == '0));
`else
    logic [31:0] unused_align;
    assign unused_align = 32'(ALIGN_LOG2);
    assign trig         = ext_trigger;
`endif

    assign win_next    = win_index + NWIN_W'(1);
    assign final_integ = (num_sh != '0) && (win_next == num_sh);
    assign final_close = (num_sh != '0) && ((win_next + NWIN_W'(1)) == num_sh);

    // One counter serves holdoff and the window; it is held clear outside those phases.
    always_comb begin
        cnt_clr    = 1'b1;
        cnt_seed   = 1'b0;
        cnt_preset = len_sh;
        case (state)
            S_HOLDOFF: begin
                cnt_preset = hold_sh;
                cnt_clr    = abort || cnt_term;
            end
            S_INTEGRATE: cnt_clr = 1'b0;
            S_CLOSE:     cnt_seed = sample_valid;
            default:     ;
        endcase
    end

    sample_window_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .seed   (cnt_seed),
        .en     (sample_valid),
        .preset (cnt_preset),
        .count  (cnt_count),
        .term   (cnt_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            len_sh      <= '0;
            hold_sh     <= '0;
            num_sh      <= '0;
            last_win    <= 1'b0;
            cap_ena     <= 1'b0;
            cap_start   <= 1'b0;
            cap_capture <= 1'b0;
            win_index   <= '0;
            win_ts      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            cap_start   <= 1'b0;
            cap_capture <= 1'b0;
            done        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (arm && !abort) begin
                        len_sh      <= (cfg_window_len == '0) ? CNT_W'(1) : cfg_window_len;
                        hold_sh     <= cfg_holdoff;
                        num_sh      <= cfg_num_windows;
                        overrun     <= 1'b0;
                        overrun_cnt <= '0;
                        win_index   <= '0;
                        last_win    <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (trig) begin
                        if (hold_sh != '0) begin
                            state <= S_HOLDOFF;
                        end else begin
                            state     <= S_INTEGRATE;
                            cap_start <= 1'b1;
                            cap_ena   <= 1'b1;
                        end
                    end
                end
                S_HOLDOFF: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (cnt_term) begin
                        state     <= S_INTEGRATE;
                        cap_start <= 1'b1;
                        cap_ena   <= 1'b1;
                    end
                end
                S_INTEGRATE: begin
                    if (sample_valid && (cnt_count == '0)) begin
                        win_ts <= in_timestamp;
                    end
                    if (abort || cnt_term) begin
                        state       <= S_CLOSE;
                        cap_capture <= 1'b1;
                        last_win    <= abort || final_integ;
                        done        <= abort || final_integ;
                    end
                end
                S_CLOSE: begin
                    win_index <= win_next;
                    if (pkt_busy) begin
                        overrun <= 1'b1;
                        if (overrun_cnt != '1) begin
                            overrun_cnt <= overrun_cnt + OVR_CNT_W'(1);
                        end
                    end
                    if (last_win || abort) begin
                        state    <= S_IDLE;
                        cap_ena  <= 1'b0;
                        busy     <= 1'b0;
                        last_win <= 1'b0;
                        done     <= !last_win;
                    end else begin
                        if (sample_valid) begin
                            win_ts <= in_timestamp;
                        end
                        // A one-sample window seeded in this cycle is already complete.
                        if (sample_valid && (len_sh == CNT_W'(1))) begin
                            cap_capture <= 1'b1;
                            last_win    <= final_close;
                            done        <= final_close;
                        end else begin
                            state <= S_INTEGRATE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_integration_scheduler.sv
// tb/tb_integration_scheduler.sv - directed scoreboard bench for integration_scheduler
module tb_integration_scheduler;

    localparam int CNT_W  = 32;
    localparam int NWIN_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              arm = 1'b0;
    logic              abort = 1'b0;
    logic              ext_trigger = 1'b0;
    logic [CNT_W-1:0]  cfg_window_len = '0;
    logic [CNT_W-1:0]  cfg_holdoff = '0;
    logic [NWIN_W-1:0] cfg_num_windows = '0;
    logic              sample_valid = 1'b0;
    logic [63:0]       in_timestamp = '0;
    logic              pkt_busy = 1'b0;
    logic              cap_ena;
    logic              cap_start;
    logic              cap_capture;
    logic [NWIN_W-1:0] win_index;
    logic [63:0]       win_ts;
    logic              busy;
    logic              done;
    logic              overrun;
    logic [15:0]       overrun_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic        done;
        logic [15:0] idx;
        logic [63:0] ts;
    } exp_t;
    exp_t sb[$];

    integration_scheduler #(
        .CNT_W      (CNT_W),
        .NWIN_W     (NWIN_W),
        .ALIGN_LOG2 (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .arm             (arm),
        .abort           (abort),
        .ext_trigger     (ext_trigger),
        .cfg_window_len  (cfg_window_len),
        .cfg_holdoff     (cfg_holdoff),
        .cfg_num_windows (cfg_num_windows),
        .sample_valid    (sample_valid),
        .in_timestamp    (in_timestamp),
        .pkt_busy        (pkt_busy),
        .cap_ena         (cap_ena),
        .cap_start       (cap_start),
        .cap_capture     (cap_capture),
        .win_index       (win_index),
        .win_ts          (win_ts),
        .busy            (busy),
        .done            (done),
        .overrun         (overrun),
        .overrun_cnt     (overrun_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [63:0] ts);
        sample_valid = 1'b1;
        in_timestamp = ts;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic expect_cap(input logic d, input logic [15:0] idx, input logic [63:0] ts);
        sb.push_back('{cyc, d, idx, ts});
    endtask

    task automatic configure_and_arm(input int len, input int hold, input int num);
        cfg_window_len  = CNT_W'(len);
        cfg_holdoff     = CNT_W'(hold);
        cfg_num_windows = NWIN_W'(num);
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pulse_trigger();
        ext_trigger = 1'b1;
        tick();
        ext_trigger = 1'b0;
    endtask

    // Every capture pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (cap_capture === 1'b1) begin
            chk("cap_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("cap_cycle", 64'(cyc), 64'(e.cyc));
                chk("cap_done", 64'(done), 64'(e.done));
                chk("cap_idx", 64'(win_index), 64'(e.idx));
                chk("cap_ts", win_ts, e.ts);
            end
        end
    end

    initial begin
        tick(3);
        chk("rst_cap_ena", 64'(cap_ena), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_win_index", 64'(win_index), 64'd0);
        chk("rst_overrun_cnt", 64'(overrun_cnt), 64'd0);
        rst = 1'b0;
        tick(2);

        // Two windows of four samples, no holdoff.
        configure_and_arm(4, 0, 2);
        chk("t1_busy_armed", 64'(busy), 64'd1);
        chk("t1_ena_armed", 64'(cap_ena), 64'd0);
        pulse_trigger();
        chk("t1_cap_start", 64'(cap_start), 64'd1);
        chk("t1_cap_ena", 64'(cap_ena), 64'd1);
        tick();
        chk("t1_cap_start_pulse", 64'(cap_start), 64'd0);
        for (int i = 1; i <= 8; i++) begin
            strobe(64'(100 + i));
            if (i == 4) expect_cap(1'b0, 16'd0, 64'd101);
            if (i == 8) expect_cap(1'b1, 16'd1, 64'd105);
            tick(7);
        end
        chk("t1_win_index_end", 64'(win_index), 64'd2);
        chk("t1_ena_end", 64'(cap_ena), 64'd0);
        chk("t1_busy_end", 64'(busy), 64'd0);

        // Holdoff of three samples, one window of two.
        configure_and_arm(2, 3, 1);
        pulse_trigger();
        chk("t2_ena_holdoff", 64'(cap_ena), 64'd0);
        tick(4);
        strobe(64'd200);
        tick(7);
        strobe(64'd201);
        chk("t2_start_early", 64'(cap_start), 64'd0);
        tick(7);
        strobe(64'd202);
        chk("t2_cap_start", 64'(cap_start), 64'd1);
        tick(7);
        strobe(64'd203);
        tick(7);
        strobe(64'd204);
        expect_cap(1'b1, 16'd0, 64'd203);
        tick(7);
        chk("t2_busy_end", 64'(busy), 64'd0);

        // Continuous mode aborted partway through the first window.
        configure_and_arm(100, 0, 0);
        pulse_trigger();
        for (int i = 1; i <= 37; i++) begin
            strobe(64'(1000 + i));
            tick(7);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expect_cap(1'b1, 16'd0, 64'd1001);
        tick();
        chk("t3_ena_after", 64'(cap_ena), 64'd0);
        chk("t3_busy_after", 64'(busy), 64'd0);
        chk("t3_done_pulse", 64'(done), 64'd0);
        chk("t3_win_index", 64'(win_index), 64'd1);
        tick(3);

        // Packetizer busy across the second close.
        configure_and_arm(2, 0, 3);
        pulse_trigger();
        strobe(64'd300);
        tick(7);
        strobe(64'd301);
        expect_cap(1'b0, 16'd0, 64'd300);
        tick(7);
        chk("t4_overrun_clear", 64'(overrun), 64'd0);
        strobe(64'd302);
        tick(7);
        pkt_busy = 1'b1;
        strobe(64'd303);
        expect_cap(1'b0, 16'd1, 64'd302);
        tick(2);
        pkt_busy = 1'b0;
        chk("t4_overrun", 64'(overrun), 64'd1);
        chk("t4_overrun_cnt", 64'(overrun_cnt), 64'd1);
        tick(5);
        strobe(64'd304);
        tick(7);
        strobe(64'd305);
        expect_cap(1'b1, 16'd2, 64'd304);
        tick(7);
        chk("t4_overrun_cnt_end", 64'(overrun_cnt), 64'd1);
        chk("t4_win_index_end", 64'(win_index), 64'd3);

        // Zero length acts as one; arm mid-run must not reload config.
        configure_and_arm(0, 0, 3);
        chk("t5_overrun_rearm", 64'(overrun), 64'd0);
        chk("t5_overrun_cnt_rearm", 64'(overrun_cnt), 64'd0);
        pulse_trigger();
        strobe(64'd400);
        expect_cap(1'b0, 16'd0, 64'd400);
        tick(7);
        cfg_window_len = CNT_W'(5);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick(6);
        strobe(64'd401);
        expect_cap(1'b0, 16'd1, 64'd401);
        tick(7);
        strobe(64'd402);
        expect_cap(1'b1, 16'd2, 64'd402);
        tick(7);
        chk("t5_busy_end", 64'(busy), 64'd0);

        // Abort wins over a coincident trigger in ARMED.
        configure_and_arm(4, 0, 1);
        abort = 1'b1;
        ext_trigger = 1'b1;
        tick();
        abort = 1'b0;
        ext_trigger = 1'b0;
        chk("t6_done", 64'(done), 64'd1);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_cap_start", 64'(cap_start), 64'd0);
        tick();
        chk("t6_done_pulse", 64'(done), 64'd0);

        // Reset in the middle of a window.
        configure_and_arm(4, 0, 0);
        pulse_trigger();
        strobe(64'd500);
        tick(7);
        strobe(64'd501);
        tick(2);
        rst = 1'b1;
        tick();
        chk("t7_busy", 64'(busy), 64'd0);
        chk("t7_cap_ena", 64'(cap_ena), 64'd0);
        chk("t7_done", 64'(done), 64'd0);
        rst = 1'b0;
        tick(3);

        // Timestamp-aligned self trigger (only when the feature is built in).
        configure_and_arm(1, 0, 1);
        strobe(64'h13);
        chk("t8_no_trig_unaligned", 64'(cap_ena), 64'd0);
        tick(7);
        strobe(64'h20);
`ifdef INTEG_SCHED_TS_ALIGN_EN
        chk("t8_align_start", 64'(cap_start), 64'd1);
        chk("t8_align_ena", 64'(cap_ena), 64'd1);
        tick(7);
        strobe(64'h28);
        expect_cap(1'b1, 16'd0, 64'h28);
        tick(7);
        chk("t8_align_busy_end", 64'(busy), 64'd0);
`else
        chk("t8_no_align_ena", 64'(cap_ena), 64'd0);
        chk("t8_no_align_busy", 64'(busy), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t8_abort_done", 64'(done), 64'd1);
        tick(2);
`endif

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/integration_scheduler.md
# integration_scheduler

Sequences integration windows for the ADC capture subsystem. Runs arm, trigger, holdoff and windowing to drive that datapath's enable, start and capture inputs, and counts samples so every window closes after exactly `cfg_window_len` samples. Sits between the register/control interface and the capture subsystem, fed by the same `sample_valid` strobe and 64-bit timestamp.

## Interface
- `CNT_W`, 32: width of window-length and holdoff counters.
- `NWIN_W`, 16: width of window-count config and window index.
- `ALIGN_LOG2`, 10: timestamp alignment granularity (log2 ticks); used only with the alignment macro.

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `arm`  in  1  pulse; latches config, IDLE -> ARMED.
- `abort`  in  1  pulse; terminates the run from any state.
- `ext_trigger`  in  1  pulse; starts the run when ARMED.
- `cfg_window_len`  in  CNT_W  samples per window; 0 is treated as 1.
- `cfg_holdoff`  in  CNT_W  samples skipped after trigger.
- `cfg_num_windows`  in  NWIN_W  windows per run; 0 means continuous.
- `sample_valid`  in  1  sample strobe, minimum spacing 8 cycles.
- `in_timestamp`  in  64  free-running timestamp.
- `pkt_busy`  in  1  packetizer still draining the previous window.
- `cap_ena`  out  1  level enable to the capture datapath.
- `cap_start`  out  1  one-cycle pulse at the start of the first window.
- `cap_capture`  out  1  one-cycle pulse closing a window.
- `win_index`  out  NWIN_W  index of the current window.
- `win_ts`  out  64  timestamp of the first sample of the current window.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse at the end of the run.
- `overrun`  out  1  sticky; capture issued while `pkt_busy` was high.
- `overrun_cnt`  out  16  saturating overrun count.

## Operation
- States: IDLE, ARMED, HOLDOFF, INTEGRATE, CLOSE.
- IDLE: `arm` latches all cfg inputs into shadow registers and clears `overrun`, `overrun_cnt` and `win_index`. Next state is ARMED. Config changes mid-run are ignored.
- ARMED: trigger -> HOLDOFF if holdoff != 0, otherwise INTEGRATE.
- HOLDOFF: counts `sample_valid`. When the count reaches the holdoff value, go to INTEGRATE on the next cycle.
- INTEGRATE: each `sample_valid` increments the sample counter. The first sample of each window latches `win_ts`. When the count reaches `window_len`, go to CLOSE.
- CLOSE (one cycle):
  - Assert `cap_capture` and increment `win_index` (wraps at 2^NWIN_W).
  - If `pkt_busy` is high, set `overrun` and increment `overrun_cnt`. The capture is still issued; window lengths never stretch.
  - If the window count is reached (nonzero config), pulse `done` and go to IDLE. Otherwise return to INTEGRATE with the sample counter reset.
  - A `sample_valid` in the CLOSE cycle counts as sample 1 of the next window, because the datapath seeds from it.
- `abort`:
  - From ARMED or HOLDOFF: go to IDLE and pulse `done`; no capture.
  - From INTEGRATE: go to CLOSE, emit a capture for the partial window, pulse `done`, then go to IDLE.
  - `abort` in CLOSE forces IDLE after CLOSE completes.
- `abort` has priority over `ext_trigger` and `arm` in the same cycle. `arm` outside IDLE is ignored.
- Counter arithmetic is unsigned CNT_W with no wrap; the terminal compare is equality.

## Timing
- All outputs are registered. Reset values are 0 for every output and the state is IDLE.
- Trigger at cycle T:
  - With holdoff 0: state is INTEGRATE at T+1, and `cap_start` and `cap_ena` are high at T+1.
  - With holdoff: `cap_start` asserts on the cycle after the final holdoff sample.
- `cap_ena` stays high from the first INTEGRATE cycle through the last CLOSE cycle inclusive, then drops.
- `cap_capture` asserts exactly one cycle after the `sample_valid` that completes the window.
- `done` is coincident with the final `cap_capture`, or with the IDLE transition on abort without capture.
- Reset mid-run: state returns to IDLE immediately; no capture or done pulse is generated.

## Configuration
- `INTEG_SCHED_TS_ALIGN_EN`: when defined, ARMED also triggers internally on the first `sample_valid` with `in_timestamp[ALIGN_LOG2-1:0]` equal to 0; `ext_trigger` still works. When undefined, only `ext_trigger` triggers and `ALIGN_LOG2` is unused.

## Structure
- `integ_sched_pkg`: state enum typedef, default widths, and the overrun counter width constant.
- Sub-module `sample_window_counter`: a CNT_W counter with clear, enable (`sample_valid`) and terminal-count flag against a preset. It is instantiated once, shared between HOLDOFF and INTEGRATE; it is cleared on state entry.

## Test plan
- Window closing: len=4, num=2, holdoff=0, samples every 8 cycles, trigger -> two `cap_capture` pulses, each one cycle after samples 4 and 8; `done` with the second; `win_index` ends at 2.
- Holdoff: holdoff=3, len=2, num=1 -> `cap_start` after sample 3; capture after sample 5; `win_ts` equals the timestamp of sample 4.
- Abort mid-window: continuous mode, len=100, abort after 37 samples -> one partial `cap_capture` plus `done` the next cycle; `cap_ena` low afterwards.
- Backpressure: `pkt_busy` held high at the second window close -> `overrun`=1, `overrun_cnt`=1, and the capture is still issued on time.
- Edge cases:
  - len=0 -> a capture after every sample.
  - `arm` during INTEGRATE is ignored.
  - `abort` and `ext_trigger` together in ARMED -> IDLE.
- With `INTEG_SCHED_TS_ALIGN_EN` and ALIGN_LOG2=4: armed, no `ext_trigger` -> INTEGRATE begins after the first sample with timestamp low nibble 0.
